// File: rtl/bsg_credit_packet_arbiter.sv
// Round-robin, packet-locking arbiter that owns the sender-side credit pool of one shared output channel.
// Zero-cycle grant: yumi_o/v_o/grant_id_o are combinational from v_i, last_i and registered state.
// Backpressure: a beat is only accepted while credits remain; a locked packet blocks all other requesters.
//
// Ports:
//   clk_i, reset_n_i     clock and synchronous active-low reset
//   v_i, last_i          per-requester beat valid / end-of-packet marker
//   yumi_o               one-hot (or zero) beat accept, per requester
//   v_o, grant_id_o      a beat is forwarded downstream, and from which requester (0 when idle)
//   credit_return_i      one credit comes back this cycle
//   credits_o            registered credit count
//   locked_o             registered packet-in-progress flag
//   error_o              sticky credit-overflow flag
module bsg_credit_packet_arbiter #(
  parameter  int els_p     = 4,
  parameter  int credits_p = 8,
  localparam int lg_els_lp = $clog2(els_p),
  localparam int cred_w_lp = $clog2(credits_p + 1)
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic [els_p-1:0]     v_i,
  input  logic [els_p-1:0]     last_i,
  output logic [els_p-1:0]     yumi_o,
  output logic                 v_o,
  output logic [lg_els_lp-1:0] grant_id_o,
  input  logic                 credit_return_i,
  output logic [cred_w_lp-1:0] credits_o,
  output logic                 locked_o,
  output logic                 error_o
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

  state_e                 state_r, state_n;
  logic [lg_els_lp-1:0]   owner_r, owner_n;
  logic [lg_els_lp-1:0]   rr_ptr_r, rr_ptr_n;
  logic [cred_w_lp-1:0]   cnt_r, cnt_n;
  logic                   err_r, err_n;

  logic                   cand_vld;
  logic [lg_els_lp-1:0]   cand_id;
  logic [lg_els_lp-1:0]   grant_id;
  logic                   beat;
  logic                   have_credit;

  function automatic logic [lg_els_lp-1:0] wrap_inc(input logic [lg_els_lp-1:0] x);
    return (int'(x) == els_p - 1) ? '0 : x + 1'b1;
  endfunction

  assign have_credit = (cnt_r != '0);

  // First valid requester at or after the round-robin pointer, wrapping.
  always_comb begin
    logic [lg_els_lp-1:0] idx;
    cand_vld = 1'b0;
    cand_id  = '0;
    idx      = '0;
    for (int i = 0; i < els_p; i++) begin
      idx = lg_els_lp'((int'(rr_ptr_r) + i) % els_p);
      if (!cand_vld && v_i[idx]) begin
        cand_vld = 1'b1;
        cand_id  = idx;
      end
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r  <= IDLE;
      owner_r  <= '0;
      rr_ptr_r <= '0;
      cnt_r    <= cred_w_lp'(credits_p);
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_n;
      owner_r  <= owner_n;
      rr_ptr_r <= rr_ptr_n;
      cnt_r    <= cnt_n;
      err_r    <= err_n;
    end
  end

  // Output logic: grant decode. Reset forces the grant off so no beat
  // is acknowledged that the (about to be cleared) state would not record.
  always_comb begin
    yumi_o   = '0;
    grant_id = '0;
    if (reset_n_i && have_credit) begin
      if (state_r == IDLE) begin
        if (cand_vld) begin
          yumi_o[cand_id] = 1'b1;
          grant_id        = cand_id;
        end
      end else if (v_i[owner_r]) begin
        yumi_o[owner_r] = 1'b1;
        grant_id        = owner_r;
      end
    end
  end

  assign beat       = |yumi_o;
  assign v_o        = beat;
  assign grant_id_o = grant_id;
  assign credits_o  = cnt_r;
  assign locked_o   = (state_r == LOCKED);
  assign error_o    = err_r;

  // Next-state logic: packet lock, pointer advance and credit accounting.
  always_comb begin
    state_n  = state_r;
    owner_n  = owner_r;
    rr_ptr_n = rr_ptr_r;
    cnt_n    = cnt_r;
    err_n    = err_r;

    if (beat) begin
      if (last_i[grant_id]) begin
        // Packet done: the next search starts just past the finishing requester.
        state_n  = IDLE;
        rr_ptr_n = wrap_inc(grant_id);
      end else begin
        state_n  = LOCKED;
        owner_n  = grant_id;
      end
    end

    // A return alongside a beat cancels out; a lone return at full count is an overflow.
    case ({beat, credit_return_i})
      2'b10: cnt_n = cnt_r - 1'b1;
      2'b01: begin
        if (cnt_r == cred_w_lp'(credits_p)) err_n = 1'b1;
        else                                 cnt_n = cnt_r + 1'b1;
      end
      default: cnt_n = cnt_r;
    endcase
  end

endmodule

// File: doc/bsg_credit_packet_arbiter.md
# bsg_credit_packet_arbiter

Round-robin, packet-locking arbiter that shares one credit-flow-controlled output channel among `els_p` requesters. It owns the sender-side credit pool. Each accepted beat consumes one credit, and each returned token restores one; the return pulses typically come from the receive-side credit counter after synchronization. It sits in front of the shared channel's data mux and drives the mux select and the per-requester yumi.

## Interface
- `els_p`, default 4: number of requesters, ≥2.
- `credits_p`, default 8: initial and maximum credit count, ≥1.
- `lg_els_lp`, derived: `$clog2(els_p)`.
- `cred_w_lp`, derived: `$clog2(credits_p+1)`.
- `clk_i` — in, 1: sole clock; all state updates on posedge.
- `reset_n_i` — in, 1: synchronous, active-low reset, sampled on `clk_i` posedge.
- `v_i` — in, `els_p`: per-requester beat valid.
- `last_i` — in, `els_p`: per-requester "this beat ends the packet"; qualified by `v_i`.
- `yumi_o` — out, `els_p`: one-hot or zero; the beat from that requester is accepted this cycle.
- `v_o` — out, 1: a beat is forwarded downstream this cycle; equals `|yumi_o`.
- `grant_id_o` — out, `lg_els_lp`: binary index of the accepted requester; valid only when `v_o`, else 0.
- `credit_return_i` — in, 1: one credit returned this cycle.
- `credits_o` — out, `cred_w_lp`: registered current credit count.
- `locked_o` — out, 1: registered; a packet is in progress.
- `error_o` — out, 1: sticky; a credit return arrived while count == `credits_p`.

## Operation
- **State:** `cnt_r` (`cred_w_lp`), `state_r` ∈ {IDLE, LOCKED}, `owner_r` (`lg_els_lp`), `rr_ptr_r` (`lg_els_lp`), `err_r`.
- **Reset** (`reset_n_i`=0 at posedge): `cnt_r`=`credits_p`, IDLE, `owner_r`=0, `rr_ptr_r`=0, `err_r`=0.
  - While `reset_n_i`=0, `yumi_o`=0, `v_o`=0 and `grant_id_o`=0, whatever `v_i` is.
- **Credit gate:** a beat may be accepted only when `cnt_r` != 0. A return in the same cycle does not bypass the gate.
- **IDLE arbitration:**
  - Candidate g = first set `v_i` bit searching `rr_ptr_r`, `rr_ptr_r`+1, … modulo `els_p`.
  - If a candidate exists and `cnt_r`!=0: `yumi_o[g]`=1 and `grant_id_o`=g.
  - If `last_i[g]`=1: stay IDLE and set `rr_ptr_r` ← (g+1) mod `els_p`.
  - If `last_i[g]`=0: go to LOCKED with `owner_r` ← g; `rr_ptr_r` is unchanged.
  - With no credit, or no candidate, there is no grant and no state change.
- **LOCKED:**
  - Only `owner_r` is eligible; all other `v_i` are ignored.
  - `yumi_o[owner_r]` = `v_i[owner_r]` & (`cnt_r`!=0).
  - On an accepted beat with `last_i[owner_r]`=1: go to IDLE and set `rr_ptr_r` ← (`owner_r`+1) mod `els_p`.
  - The owner may idle (`v_i` low) for any number of cycles; the lock is held.
- **Credit arithmetic:** `cnt_r` ← `cnt_r` − `v_o` + `credit_return_i`.
  - Simultaneous beat and return: `cnt_r` is unchanged.
  - Return at `cnt_r`==`credits_p` with no beat: `cnt_r` holds at `credits_p` (saturate, no wrap) and `err_r` ← 1. `err_r` clears only on reset.
  - Underflow cannot occur, because of the credit gate.
- **Outputs:** `credits_o`=`cnt_r`, `locked_o`=(`state_r`==LOCKED), `error_o`=`err_r`.
- **Reset mid-packet:** the lock is dropped, credits are refilled to `credits_p`, and in-flight beats are the environment's responsibility.

## Timing
- `v_i`/`last_i`/`cnt_r`/`state_r` → `yumi_o`/`v_o`/`grant_id_o` is combinational, with zero-cycle grant latency.
- Requesters must hold data stable while `v_i`=1 until `yumi_o`.
- `credits_o`, `locked_o` and `rr_ptr_r` reflect a beat or return on the following cycle.
- A credit returned in cycle t enables a beat no earlier than cycle t+1.
- No combinational path from `credit_return_i` to any output.
- One beat maximum per cycle.

## Test plan
1. **Reset values:** `reset_n_i`=0 for 2 cycles with `v_i`=4'b1111 → `yumi_o`=0, `v_o`=0, `credits_o`=8, `locked_o`=0, `error_o`=0. Release, next cycle → `yumi_o`=4'b0001.
2. **Round-robin fairness:** all four requesters hold single-beat packets (`last_i`=1) continuously, with a return every cycle → grants 0,1,2,3,0,… and `credits_o` stays 8.
3. **Packet lock:** req1 sends 3 beats (`last_i` on beat 3) while req0/2 are valid.
   - Expect `yumi_o`=4'b0010 for 3 accepted beats and `locked_o`=1 through beat 3.
   - Req1 idles 2 cycles mid-packet → no grant to others.
   - Next grant after the packet goes to req2.
4. **Credit exhaustion:** no returns, req0 streams 10 single-beat packets → exactly 8 accepted, `credits_o` reaches 0, `yumi_o`=0 thereafter. Pulse `credit_return_i` once at cycle t → one beat at t+1.
5. **Simultaneous and overflow:**
   - Beat plus return in the same cycle at `credits_o`=5 → stays 5.
   - With no traffic at `credits_o`=8, pulse return → `credits_o` stays 8 and `error_o`=1 sticky until reset.
6. **Reset mid-packet:** req2 locked after beat 1 with `credits_o`=6, then `reset_n_i`=0 one cycle → `locked_o`=0, `credits_o`=8, and after release the arbitration restarts at req0.
